pipe_operand_mux: RTL
=====================

Name: pipe_operand_mux

Overview:
- Parametrised N-way operand-select multiplexer with a built-in pipeline register.
- Generalises the fixed 2:1 and 3:1 32-bit selects used in the 5-stage RISC-V datapath (ID/EX operand and forwarding selects).
- Adds configurable width and input count, one-cycle registered output, valid tracking, and stall/flush control matching the pipeline hazard unit.
- Instantiated at the EX-stage operand inputs, replacing a combinational select followed by a separate pipeline register.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the input to capture.
- in_valid  input  1  upstream slot holds a real instruction.
- stall  input  1  hold the current register contents.
- flush  input  1  insert a bubble.
- out_data  output  WIDTH  registered selected operand.
- out_valid  output  1  out_data belongs to a valid instruction.
- out_sel  output  SEL_W  registered copy of the sel value that was captured (debug/forwarding trace).

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Priority each edge: rst > flush > stall > load.
- rst=1: out_data=0, out_valid=0, out_sel=0.
- flush=1 (rst=0):
  - out_valid<=0, out_data<=0, out_sel<=0.
  - Flush overrides a simultaneous stall.
- stall=1 (rst=0, flush=0):
  - out_data, out_valid and out_sel all hold.
  - in_bus, sel and in_valid are ignored.
- load (no rst/flush/stall):
  - out_valid<=in_valid; out_sel<=sel.
  - If in_valid=1: out_data<=input[sel] when sel<NUM_IN, otherwise out_data<=0.
  - If in_valid=0: out_data holds its previous value; only out_valid drops.
- Latency: exactly 1 cycle from sel/in_bus/in_valid to out_* when not stalled.
- Stalled data is released on the first edge after stall deasserts, provided flush=0.
- No combinational path from any input to any output; all outputs are registered.
- Out-of-range sel (NUM_IN <= sel < 2**SEL_W):
  - Yields zero data and is not itself an error in the base build.
  - in_valid still propagates to out_valid.
- Back-to-back loads with differing sel are supported every cycle with no dead cycle.
- Reset asserted mid-stall clears all state immediately; after reset deasserts, the block loads on the next edge.

Optional Feature:
- Macro: PIPE_OPERAND_MUX_SELERR_EN.
- Defined: adds two outputs, sel_err (1 bit) and sel_err_cnt (8 bits).
  - sel_err is a sticky flag, set on any load edge with in_valid=1 and sel>=NUM_IN.
  - sel_err_cnt increments on each such edge and saturates at 255.
  - Both are cleared only by rst; flush and stall do not affect them.
  - The counter does not count during stall.
- Not defined: the ports do not exist and no error logic is built. Out-of-range select behaviour on out_data is identical in both builds.

Test Plan:
- Defaults (WIDTH=32, NUM_IN=3). in_bus = {C,B,A} with A=0x11111111, B=0x22222222, C=0x33333333. Drive sel=1, in_valid=1 for one edge -> next cycle out_data=0x22222222, out_valid=1, out_sel=1.
- sel=3, in_valid=1 -> out_data=0x00000000, out_valid=1. With the macro defined: sel_err=1 and sel_err_cnt=1; a second sel=3 load gives sel_err_cnt=2.
- Load sel=2 (out_data=0x33333333), then stall=1 for 3 cycles while sel=0 -> out_data stays 0x33333333, out_valid=1. After stall drops: out_data=0x11111111 one cycle later.
- stall=1 and flush=1 on the same edge -> out_valid=0, out_data=0. Then in_valid=0 with sel=1 -> out_valid=0, out_data remains 0.
- Assert rst during a stall holding 0x22222222 -> all outputs 0 on that edge. With the macro defined, sel_err and sel_err_cnt also clear.
- NUM_IN=5, WIDTH=8, SEL_W=3. Sweep sel 0..7 on consecutive cycles with distinct input bytes 0xA0..0xA4 -> out_data sequence is 0xA0..0xA4 followed by 0x00 three times, one cycle delayed, with no bubbles.

Source files
------------

// File: rtl/pipe_operand_mux.sv
// N-way operand select with a one-cycle output register, valid tracking and stall/flush control.
// Define PIPE_OPERAND_MUX_SELERR_EN to add the sticky out-of-range select flag and its saturating counter.
module pipe_operand_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel
`ifdef PIPE_OPERAND_MUX_SELERR_EN
    ,
    output logic                    sel_err,
    output logic [7:0]              sel_err_cnt
`endif
);

    if (NUM_IN < 2 || NUM_IN > 16 || (2 ** SEL_W) < NUM_IN) begin : g_bad_params
        $error("pipe_operand_mux: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
    end

    logic [WIDTH-1:0] sel_data;
    logic             load_en;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    // Out-of-range selects fall through to the zero default.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en = !flush && !stall;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end else if (!stall) begin
            out_valid_d = in_valid;
            out_sel_d   = sel;
            // A bubble only drops valid; the operand value is left in place.
            if (in_valid) begin
                out_data_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

`ifdef PIPE_OPERAND_MUX_SELERR_EN
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic       err_hit;
    logic       sel_err_q, sel_err_d;
    logic [7:0] sel_err_cnt_q, sel_err_cnt_d;

    // Error state is only cleared by rst; flush and stall leave it alone.
    always_comb begin
        err_hit       = load_en && in_valid && ({1'b0, sel} >= NUM_IN_W);
        sel_err_d     = sel_err_q | err_hit;
        sel_err_cnt_d = sel_err_cnt_q;
        if (err_hit && sel_err_cnt_q != 8'hFF) begin
            sel_err_cnt_d = sel_err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q     <= 1'b0;
            sel_err_cnt_q <= '0;
        end else begin
            sel_err_q     <= sel_err_d;
            sel_err_cnt_q <= sel_err_cnt_d;
        end
    end

    assign sel_err     = sel_err_q;
    assign sel_err_cnt = sel_err_cnt_q;
`endif

endmodule
